vp_dram_seq: RTL and testbench
==============================

# vp_dram_seq

DRAM cycle sequencer for the 1801VP1-119 memory controller path.
- Arbitrates between bus access requests and refresh ticks derived from the refresh clock.
- Generates the RAS/CAS/WE strobes for two DRAM banks.
- Steps the 74LS630 EDAC through its S1:S0 modes: generate, check, latch, correct.
- Sits between the Q-bus front end (request/ack) and the DRAM/EDAC pins.

## Interface
- ROW_W, 8: refresh row counter width.
- RP_CYC, 2: RAS precharge clocks after every cycle (≥1).

- PIN_CLK  in  1  primary clock
- PIN_DCLO  in  1  reset; synchronous, active-high
- PIN_RCLK  in  1  refresh clock, asynchronous, period ≥ 8 PIN_CLK
- PIN_DCE  in  1  runtime EDAC correction enable
- acc_req  in  1  access request, level; held until acc_ack seen
- acc_wr  in  1  write (1) / read (0); sampled at accept
- acc_byte  in  1  byte write; sampled at accept
- acc_bank  in  1  bank select (0→nRAS0, 1→nRAS1); sampled at accept
- acc_ack  out  1  cycle done; reply to bus
- nRAS0, nRAS1, nCAS, nWE, nWEC  out  1 each  DRAM strobes; active low; nWEC writes check bits
- S0, S1  out  1 each  74LS630 mode
- SEF, DEF  in  1 each  EDAC single/double error flags
- addr_sel  out  2  address mux: 00 row, 01 column, 10 refresh row
- merge  out  1  data mux: bus byte over corrected word
- ref_row  out  ROW_W  refresh row address
- err_dbl  out  1  one-clock pulse on uncorrectable read
- ref_miss  out  1  one-clock pulse on a lost refresh tick

## Operation
States: IDLE, REF, RAS, RCAS, LATCH, CORR, MRG, WCAS, REPLY, PRE.

Refresh path:
- PIN_RCLK goes through a 2-flop synchronizer; each rising edge sets ref_pend.
- A rising edge while ref_pend is already set pulses ref_miss.

IDLE:
- ref_pend has priority over acc_req.
- Refresh (ref_pend set): → REF.
- Access (ref_pend clear, acc_req high): latch wr/byte/bank, → RAS.

REF:
- nRAS0 and nRAS1 low for 2 clocks; addr_sel=10.
- Clear ref_pend; ref_row +1 at exit, wraps all-ones→0.
- → PRE.

RAS: selected nRAS low, addr_sel=00, 1 clock.

Word read:
- RCAS: nCAS low, addr_sel=01, S=01.
- If EDAC active: LATCH (S=11), then CORR (S=10) only when SEF=1.
- Then REPLY.

Word write:
- WCAS: nCAS, nWE, nWEC low, S=00.
- Then REPLY.

Byte write, EDAC active (read-modify-write):
- RCAS → LATCH → CORR (always).
- MRG: nCAS high, merge=1, S=00, 1 clock.
- WCAS: merge=1.
- Then REPLY.

REPLY:
- acc_ack=1; strobes held.
- Stays until acc_req=0.
- Then PRE: all strobes high, S=01, RP_CYC clocks, → IDLE.

Errors:
- DEF=1 in LATCH pulses err_dbl; the cycle still replies.

Abort / reset:
- acc_req dropping before REPLY completes the DRAM cycle, skips acc_ack, goes to PRE.
- PIN_DCLO high mid-cycle: next clock all outputs at reset values, state IDLE, ref_pend cleared.

EDAC active = macro defined AND PIN_DCE=1.
- With EDAC inactive, reads skip LATCH/CORR.
- With EDAC inactive, byte writes take the word-write path.
- Check bits (S=00, nWEC) are still written on every write whenever the macro is defined.

## Timing
Reset values:
- nRAS0, nRAS1, nCAS, nWE, nWEC = 1.
- S1:S0 = 01.
- acc_ack, merge, err_dbl, ref_miss = 0.
- addr_sel = 00, ref_row = 0, state IDLE.

Cycle counts (request seen in IDLE at clock 0; "ack at N" = acc_ack first high at clock N):

| Access | EDAC | Path | ack at |
|---|---|---|---|
| Read | inactive | RAS(1) RCAS(2) | 3 |
| Read | active, SEF=0 | RAS RCAS LATCH | 4 |
| Read | active, SEF=1 | RAS RCAS LATCH CORR | 5 |
| Word write | any | RAS(1) WCAS(2) | 3 |
| Byte RMW | active | RAS RCAS LATCH CORR MRG WCAS | 7 |

Other timing:
- Refresh: 2 clocks of REF plus RP_CYC clocks of PRE.
- A pending request waits until refresh PRE ends.
- Outputs are registered; no combinational path from inputs to strobes.
- Refresh tick to ref_pend: 3 clocks.

## Configuration
- VP119_EDAC_EN defined:
  - EDAC sequencing as above, gated at runtime by PIN_DCE.
  - err_dbl active.
- VP119_EDAC_EN undefined:
  - S1:S0 tied 01, nWEC tied 1, merge and err_dbl tied 0.
  - LATCH, CORR and MRG are not built.
  - Byte writes use the word-write path.

## Test plan
- Reset mid-RCAS:
  - Stimulus: read request; at clock 2 assert PIN_DCLO for 1 clock.
  - Response: next clock all strobes 1, S=01, acc_ack=0; a following request starts RAS one clock after accept.
- Word read:
  - Stimulus: EDAC on, SEF=0, acc_wr=0, bank 1.
  - Response: nRAS1 low at 1; nCAS low at 2; S=11 at 3; acc_ack at 4; nRAS0 stays 1.
- Corrected read:
  - Stimulus: SEF=1 in LATCH.
  - Response: S=10 at 4; acc_ack at 5; no err_dbl.
  - Stimulus: DEF=1 in LATCH.
  - Response: err_dbl pulse at 4.
- Byte RMW:
  - Stimulus: acc_wr=1, acc_byte=1, EDAC on.
  - Response: S sequence 01,11,10,00,00; merge=1 during MRG and WCAS; nWE/nWEC low only in WCAS; acc_ack at 7.
- Refresh arbitration:
  - Stimulus: RCLK edge and acc_req in the same IDLE clock; ROW_W=2 with ref_row=3.
  - Response: REF first, both nRAS low for 2 clocks; ref_row wraps to 0; access RAS right after PRE.
  - Stimulus: second RCLK edge while refresh still pending.
  - Response: ref_miss pulses.
- Abort:
  - Stimulus: acc_req dropped at clock 2 of a word write.
  - Response: write strobes complete; acc_ack never asserted; PRE then IDLE.

Source files
------------

// File: rtl/vp_dram_seq.sv
// DRAM cycle sequencer: refresh/access arbitration, RAS/CAS/WE strobes, 74LS630 mode stepping.
// Optional EDAC sequencing is built only when VP119_EDAC_EN is defined.
module vp_dram_seq #(
    parameter int ROW_W  = 8,
    parameter int RP_CYC = 2
) (
    input  logic             PIN_CLK,
    input  logic             PIN_DCLO,
    input  logic             PIN_RCLK,
    input  logic             PIN_DCE,
    input  logic             acc_req,
    input  logic             acc_wr,
    input  logic             acc_byte,
    input  logic             acc_bank,
    output logic             acc_ack,
    output logic             nRAS0,
    output logic             nRAS1,
    output logic             nCAS,
    output logic             nWE,
    output logic             nWEC,
    output logic             S0,
    output logic             S1,
    input  logic             SEF,
    input  logic             DEF,
    output logic [1:0]       addr_sel,
    output logic             merge,
    output logic [ROW_W-1:0] ref_row,
    output logic             err_dbl,
    output logic             ref_miss
);

    localparam int CNT_W = $clog2((RP_CYC > 2) ? RP_CYC : 2);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(RP_CYC - 1);
    localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(1);

    typedef enum logic [3:0] {
        IDLE, REF, RAS, RCAS, LATCH, CORR, MRG, WCAS, REPLY, PRE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sync_q;
    logic             ref_pend_q, ref_pend_d;
    logic [ROW_W-1:0] ref_row_q, ref_row_d;
    logic             wr_q, wr_d, rmw_q, rmw_d, bank_q, bank_d;
    logic             edac_q, edac_d, abort_q, abort_d;
    logic             ras0_n_q, ras0_n_d, ras1_n_q, ras1_n_d, cas_n_q, cas_n_d;
    logic             we_n_q, we_n_d, wec_n_q, wec_n_d;
    logic [1:0]       s_q, s_d, addr_q, addr_d;
    logic             merge_q, merge_d, ack_q, ack_d;
    logic             err_q, err_d, miss_q, miss_d;
    logic             edac_on, rclk_rise, ref_take, req_ok;
    state_t           end_state;

`ifdef VP119_EDAC_EN
    assign edac_on = PIN_DCE;
`else
    assign edac_on = 1'b0;
    logic unused_edac;
    assign unused_edac = ^{PIN_DCE, SEF, DEF};
`endif

    assign rclk_rise = sync_q[1] & ~sync_q[2];
    // An abort seen at any point of the DRAM cycle suppresses the reply.
    assign req_ok    = acc_req & ~abort_q;
    assign end_state = req_ok ? REPLY : PRE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rmw_d     = rmw_q;
        bank_d    = bank_q;
        edac_d    = edac_q;
        abort_d   = abort_q;
        ref_take  = 1'b0;
        ref_row_d = ref_row_q;
        err_d     = 1'b0;
        if (state_q inside {RAS, RCAS, LATCH, CORR, MRG, WCAS} && !acc_req)
            abort_d = 1'b1;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (ref_pend_q) begin
                    ref_take = 1'b1;
                    cnt_d    = REF_LOAD;
                    state_d  = REF;
                end else if (acc_req) begin
                    wr_d    = acc_wr;
                    bank_d  = acc_bank;
                    edac_d  = edac_on;
                    rmw_d   = acc_wr & acc_byte & edac_on;
                    state_d = RAS;
                end
            end
            REF: begin
                if (cnt_q == '0) begin
                    ref_row_d = ref_row_q + ROW_W'(1);
                    cnt_d     = PRE_LOAD;
                    state_d   = PRE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RAS: begin
                cnt_d   = PRE_LOAD;
                state_d = (wr_q && !rmw_q) ? WCAS : RCAS;
            end
            RCAS: begin
                cnt_d   = PRE_LOAD;
                state_d = edac_q ? LATCH : end_state;
            end
`ifdef VP119_EDAC_EN
            LATCH: begin
                cnt_d   = PRE_LOAD;
                err_d   = DEF;
                state_d = (rmw_q || SEF) ? CORR : end_state;
            end
            CORR: begin
                cnt_d   = PRE_LOAD;
                state_d = rmw_q ? MRG : end_state;
            end
            MRG: begin
                cnt_d   = PRE_LOAD;
                state_d = WCAS;
            end
`endif
            WCAS: begin
                cnt_d   = PRE_LOAD;
                state_d = end_state;
            end
            REPLY: begin
                cnt_d = PRE_LOAD;
                if (!acc_req)
                    state_d = PRE;
            end
            PRE: begin
                if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign ref_pend_d = rclk_rise | (ref_pend_q & ~ref_take);
    assign miss_d     = rclk_rise & ref_pend_q & ~ref_take;

    // Outputs are decoded from the next state so each strobe is a flop output.
    always_comb begin
        ras0_n_d = 1'b1;
        ras1_n_d = 1'b1;
        cas_n_d  = 1'b1;
        we_n_d   = 1'b1;
        wec_n_d  = 1'b1;
        s_d      = 2'b01;
        addr_d   = 2'b00;
        merge_d  = 1'b0;
        ack_d    = (state_d == REPLY);
        if (state_d inside {RAS, RCAS, LATCH, CORR, MRG, WCAS}) begin
            ras0_n_d = bank_d;
            ras1_n_d = ~bank_d;
        end
        case (state_d)
            REF: begin
                ras0_n_d = 1'b0;
                ras1_n_d = 1'b0;
                addr_d   = 2'b10;
            end
            RCAS: begin
                cas_n_d = 1'b0;
                addr_d  = 2'b01;
            end
`ifdef VP119_EDAC_EN
            LATCH: begin
                cas_n_d = 1'b0;
                addr_d  = 2'b01;
                s_d     = 2'b11;
            end
            CORR: begin
                cas_n_d = 1'b0;
                addr_d  = 2'b01;
                s_d     = 2'b10;
            end
            MRG: begin
                addr_d  = 2'b01;
                s_d     = 2'b00;
                merge_d = 1'b1;
            end
`endif
            WCAS: begin
                cas_n_d = 1'b0;
                we_n_d  = 1'b0;
                addr_d  = 2'b01;
`ifdef VP119_EDAC_EN
                wec_n_d = 1'b0;
                s_d     = 2'b00;
                merge_d = rmw_d;
`endif
            end
            REPLY: begin
                ras0_n_d = ras0_n_q;
                ras1_n_d = ras1_n_q;
                cas_n_d  = cas_n_q;
                we_n_d   = we_n_q;
                wec_n_d  = wec_n_q;
                s_d      = s_q;
                addr_d   = addr_q;
                merge_d  = merge_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PIN_CLK) begin
        if (PIN_DCLO) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sync_q     <= '0;
            ref_pend_q <= 1'b0;
            ref_row_q  <= '0;
            wr_q       <= 1'b0;
            rmw_q      <= 1'b0;
            bank_q     <= 1'b0;
            edac_q     <= 1'b0;
            abort_q    <= 1'b0;
            ras0_n_q   <= 1'b1;
            ras1_n_q   <= 1'b1;
            cas_n_q    <= 1'b1;
            we_n_q     <= 1'b1;
            wec_n_q    <= 1'b1;
            s_q        <= 2'b01;
            addr_q     <= 2'b00;
            merge_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= {sync_q[1:0], PIN_RCLK};
            ref_pend_q <= ref_pend_d;
            ref_row_q  <= ref_row_d;
            wr_q       <= wr_d;
            rmw_q      <= rmw_d;
            bank_q     <= bank_d;
            edac_q     <= edac_d;
            abort_q    <= abort_d;
            ras0_n_q   <= ras0_n_d;
            ras1_n_q   <= ras1_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            wec_n_q    <= wec_n_d;
            s_q        <= s_d;
            addr_q     <= addr_d;
            merge_q    <= merge_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            miss_q     <= miss_d;
        end
    end

    assign acc_ack  = ack_q;
    assign nRAS0    = ras0_n_q;
    assign nRAS1    = ras1_n_q;
    assign nCAS     = cas_n_q;
    assign nWE      = we_n_q;
    assign nWEC     = wec_n_q;
    assign S1       = s_q[1];
    assign S0       = s_q[0];
    assign addr_sel = addr_q;
    assign merge    = merge_q;
    assign ref_row  = ref_row_q;
    assign err_dbl  = err_q;
    assign ref_miss = miss_q;

endmodule

// File: tb/tb_vp_dram_seq.sv
// Directed bench for vp_dram_seq; expectations follow whether VP119_EDAC_EN is defined.
module tb_vp_dram_seq;

`ifdef VP119_EDAC_EN
    localparam bit EDAC = 1'b1;
`else
    localparam bit EDAC = 1'b0;
`endif

    logic clk, dclo, rclk, dce, req, wr, byt, bank, sef, def;
    logic ack, nras0, nras1, ncas, nwe, nwec, s0, s1, mrg, err, miss;
    logic [1:0] addr;
    logic [1:0] row;
    logic [4:0] strb;
    logic [1:0] s;
    int n_chk, n_pass;
    logic [4:0] e_strb [0:6];
    logic [1:0] e_s    [0:6];
    logic       e_mrg  [0:6];
    logic       e_ack  [0:6];

    assign strb = {nras0, nras1, ncas, nwe, nwec};
    assign s    = {s1, s0};

    vp_dram_seq #(.ROW_W(2), .RP_CYC(2)) dut (
        .PIN_CLK(clk), .PIN_DCLO(dclo), .PIN_RCLK(rclk), .PIN_DCE(dce),
        .acc_req(req), .acc_wr(wr), .acc_byte(byt), .acc_bank(bank),
        .acc_ack(ack), .nRAS0(nras0), .nRAS1(nras1), .nCAS(ncas), .nWE(nwe), .nWEC(nwec),
        .S0(s0), .S1(s1), .SEF(sef), .DEF(def), .addr_sel(addr), .merge(mrg),
        .ref_row(row), .err_dbl(err), .ref_miss(miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic b, input logic bk);
        wr = w; byt = b; bank = bk; req = 1'b1;
    endtask

    task automatic release_bus();
        req = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_pass = 0;
        dclo = 1'b1; rclk = 1'b0; dce = 1'b1; req = 1'b0; wr = 1'b0;
        byt = 1'b0; bank = 1'b0; sef = 1'b0; def = 1'b0;
        repeat (3) tick();
        check("rst_strb", 32'(strb), 32'h1f);
        check("rst_s", 32'(s), 32'h1);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_row", 32'(row), 32'h0);
        check("rst_pulses", 32'({mrg, err, miss}), 32'h0);
        dclo = 1'b0;
        tick();
        $display("txn reset");

        // word read, bank 1
        start(1'b0, 1'b0, 1'b1);
        tick(); check("rd_c1_strb", 32'(strb), 32'h17); check("rd_c1_addr", 32'(addr), 32'h0);
        tick(); check("rd_c2_strb", 32'(strb), 32'h13); check("rd_c2_addr", 32'(addr), 32'h1);
        tick(); check("rd_c3_s", 32'(s), EDAC ? 32'h3 : 32'h1); check("rd_c3_ack", 32'(ack), 32'(!EDAC));
        tick(); check("rd_c4_ack", 32'(ack), 32'h1); check("rd_c4_nras0", 32'(nras0), 32'h1);
        release_bus();
        $display("txn word_read");

        // corrected read, bank 0
        sef = 1'b1;
        start(1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("cor_c4_s", 32'(s), EDAC ? 32'h2 : 32'h1);
        check("cor_c4_ack", 32'(ack), 32'(!EDAC));
        check("cor_c4_err", 32'(err), 32'h0);
        tick(); check("cor_c5_ack", 32'(ack), 32'h1);
        release_bus();
        sef = 1'b0;
        $display("txn corrected_read");

        // uncorrectable read
        def = 1'b1;
        start(1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("dbl_c4_err", 32'(err), 32'(EDAC));
        check("dbl_c4_ack", 32'(ack), 32'h1);
        tick(); check("dbl_c5_err", 32'(err), 32'h0);
        release_bus();
        def = 1'b0;
        $display("txn double_error_read");

        // byte write: read-modify-write when EDAC built, plain write otherwise
        if (EDAC) begin
            e_strb = '{5'h0f, 5'h0b, 5'h0b, 5'h0b, 5'h0f, 5'h08, 5'h08};
            e_s    = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
            e_mrg  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            e_ack  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        end else begin
            e_strb = '{5'h0f, 5'h09, 5'h09, 5'h09, 5'h09, 5'h09, 5'h09};
            e_s    = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
            e_mrg  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            e_ack  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        end
        start(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c < 6) begin
                check($sformatf("rmw_c%0d_strb", c + 1), 32'(strb), 32'(e_strb[c]));
                check($sformatf("rmw_c%0d_s", c + 1), 32'(s), 32'(e_s[c]));
                check($sformatf("rmw_c%0d_merge", c + 1), 32'(mrg), 32'(e_mrg[c]));
            end
            check($sformatf("rmw_c%0d_ack", c + 1), 32'(ack), 32'(e_ack[c]));
        end
        release_bus();
        $display("txn byte_write");

        // word write, bank 1
        start(1'b1, 1'b0, 1'b1);
        tick(); check("wr_c1_strb", 32'(strb), 32'h17);
        tick(); check("wr_c2_strb", 32'(strb), 32'({4'b1000, !EDAC}));
        check("wr_c2_s", 32'(s), EDAC ? 32'h0 : 32'h1);
        tick(); check("wr_c3_ack", 32'(ack), 32'h1);
        release_bus();
        $display("txn word_write");

        // abort: request dropped in the write CAS clock
        start(1'b1, 1'b0, 1'b0);
        tick(); tick();
        req = 1'b0;
        check("abt_c2_strb", 32'(strb), 32'({4'b0100, !EDAC}));
        for (int c = 3; c <= 6; c++) begin
            tick();
            check($sformatf("abt_c%0d_ack", c), 32'(ack), 32'h0);
            if (c == 3) check("abt_c3_strb", 32'(strb), 32'h1f);
        end
        repeat (4) tick();
        $display("txn abort");

        // synchronous reset in the middle of a read
        start(1'b0, 1'b0, 1'b0);
        tick(); tick();
        check("rmid_c2_strb", 32'(strb), 32'h0b);
        dclo = 1'b1;
        tick();
        check("rmid_c3_strb", 32'(strb), 32'h1f);
        check("rmid_c3_s", 32'(s), 32'h1);
        check("rmid_c3_ack", 32'(ack), 32'h0);
        dclo = 1'b0;
        tick(); check("rmid_c4_strb", 32'(strb), 32'h0f);
        release_bus();
        $display("txn reset_mid_cycle");

        // refresh: tick to REF latency, both RAS low for two clocks
        rclk = 1'b1;
        tick(); tick(); tick();
        check("ref_c3_strb", 32'(strb), 32'h1f);
        tick();
        check("ref_c4_strb", 32'(strb), 32'h07);
        check("ref_c4_addr", 32'(addr), 32'h2);
        check("ref_c4_row", 32'(row), 32'h0);
        rclk = 1'b0;
        tick(); check("ref_c5_strb", 32'(strb), 32'h07);
        tick(); check("ref_c6_strb", 32'(strb), 32'h1f); check("ref_c6_row", 32'(row), 32'h1);
        repeat (6) tick();
        for (int k = 2; k <= 3; k++) begin
            rclk = 1'b1; repeat (4) tick();
            rclk = 1'b0; repeat (8) tick();
            check($sformatf("ref_row_%0d", k), 32'(row), 32'(k));
        end
        $display("txn refresh");

        // refresh and request in the same idle clock: refresh wins, row wraps
        rclk = 1'b1;
        tick(); tick(); tick();
        start(1'b0, 1'b0, 1'b0);
        tick();
        check("arb_c4_strb", 32'(strb), 32'h07);
        check("arb_c4_row", 32'(row), 32'h3);
        tick(); check("arb_c5_strb", 32'(strb), 32'h07);
        rclk = 1'b0;
        tick(); check("arb_c6_row", 32'(row), 32'h0); check("arb_c6_strb", 32'(strb), 32'h1f);
        tick(); check("arb_c7_strb", 32'(strb), 32'h1f);
        tick(); check("arb_c8_strb", 32'(strb), 32'h1f);
        tick(); check("arb_c9_strb", 32'(strb), 32'h0f);
        release_bus();
        $display("txn refresh_arbitration");

        // lost refresh tick while the bus holds the sequencer in reply
        start(1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        check("miss_reply_ack", 32'(ack), 32'h1);
        rclk = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 4) rclk = 1'b0;
            if (t == 8) rclk = 1'b1;
            if (t == 3 || t == 10 || t == 12) check($sformatf("miss_t%0d", t), 32'(miss), 32'h0);
            if (t == 11) check("miss_t11", 32'(miss), 32'h1);
        end
        check("miss_hold_ack", 32'(ack), 32'h1);
        rclk = 1'b0;
        release_bus();
        repeat (10) tick();
        check("miss_row_after", 32'(row), 32'h1);
        $display("txn refresh_miss");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
